// File: rtl/pt_byte_packer.sv
// Byte-serial plaintext packer: gathers up to NBYTES bytes MSB-first into one frame
// and hands the frame plus its real-byte count to the encryption stage.
module pt_byte_packer #(
  parameter int unsigned NBYTES = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_text,
  output logic [4:0]            out_count
);

  localparam int unsigned FRAME_W = 8 * NBYTES;
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   text_q, text_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 xfer_c;

  // in_ready decodes straight from state so it reads 1 during reset
  assign in_ready  = (state_q == FILL);
  assign xfer_c    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_text  = text_q;
  assign out_count = count_q;

  // Next-state: fill bytes at idx, close on last index or in_last, clear on hand-off
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    text_d  = text_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      FILL: begin
        if (xfer_c) begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx_q == CNT_W'(k)) text_d[FRAME_W-1-8*k -: 8] = in_byte;
          end
          idx_d = idx_q + CNT_W'(1);
          if (in_last || (idx_q == LAST_IDX)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = idx_q + CNT_W'(1);
            idx_d   = '0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          valid_d = 1'b0;
          idx_d   = '0;
          text_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        text_d  = '0;
        count_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      text_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      text_q  <= text_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_pt_byte_packer.sv
// Directed self-checking bench for pt_byte_packer.
module tb_pt_byte_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [247:0] out_text;
  logic [4:0]   out_count;

  int tests_run    = 0;
  int tests_failed = 0;

  pt_byte_packer #(.NBYTES(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_text !== 248'h0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b count=%0d ready=%b text=%h, want 0/0/1/0",
               out_valid, out_count, in_ready, out_text);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    logic [247:0] exp_text;
    int early_valid;
    exp_text = '0;
    early_valid = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 31; k++) begin
      exp_text[247-8*k -: 8] = 8'(k + 1);
      if (k > 0 && out_valid !== 1'b0) early_valid++;
      in_valid = 1'b1; in_byte = 8'(k + 1); in_last = 1'b0;
      step();
    end
    tests_run++;
    if (early_valid != 0) begin
      tests_failed++;
      $display("FAIL full_no_early_valid: %0d early cycles, want 0", early_valid);
    end
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_valid: valid=%b ready=%b, want 1/0", out_valid, in_ready);
    end
    tests_run++;
    if (out_text[247:240] !== 8'h01 || out_text[7:0] !== 8'h1F || out_count !== 5'd31) begin
      tests_failed++;
      $display("FAIL full_ends: first=%h last=%h count=%0d, want 01/1f/31",
               out_text[247:240], out_text[7:0], out_count);
    end
    tests_run++;
    if (out_text !== exp_text) begin
      tests_failed++;
      $display("FAIL full_text: got %h want %h", out_text, exp_text);
    end
    // in_valid still high during HOLD must not register anything
    in_byte = 8'h77;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_one_cycle: valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_short_frame();
    out_ready = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_text !== {24'hAABBCC, 224'h0} || out_count !== 5'd3) begin
      tests_failed++;
      $display("FAIL short_frame: valid=%b count=%0d text=%h, want 1/3/aabbcc00..",
               out_valid, out_count, out_text);
    end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 31; k++) send(8'hFF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_byte = 8'(c * 17 + 3); in_last = c[0];
      step();
      if (out_valid !== 1'b1 || out_text !== {248{1'b1}} || out_count !== 5'd31 || in_ready !== 1'b0)
        bad++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0 (count=%0d)", bad, out_count);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: valid=%b, want 0", out_valid);
    end
    send(8'h42, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_text !== {8'h42, 240'h0} || out_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL residue: valid=%b count=%0d text=%h, want 1/1/42 then zeros",
               out_valid, out_count, out_text);
    end
    step();
  endtask

  task automatic test_gaps();
    logic [15:0]  pat;
    logic [247:0] exp_text;
    int sent, cyc;
    pat = 16'b1011_0010_1110_0110;
    exp_text = '0;
    sent = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (sent < 31 && cyc < 300) begin
      if (pat[cyc % 16]) begin
        in_valid = 1'b1; in_byte = 8'(8'h80 + sent); in_last = 1'b0;
        exp_text[247-8*sent -: 8] = 8'(8'h80 + sent);
        sent++;
      end else begin
        in_valid = 1'b0; in_byte = 8'(cyc); in_last = 1'b1;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (sent != 31) begin
      tests_failed++;
      $display("FAIL gaps_budget: sent %0d bytes, want 31", sent);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_text !== exp_text || out_count !== 5'd31) begin
      tests_failed++;
      $display("FAIL gaps_frame: valid=%b count=%0d text=%h want %h",
               out_valid, out_count, out_text, exp_text);
    end
    step();
  endtask

  task automatic test_mid_reset();
    logic [247:0] exp_text;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) send(8'(8'hE0 + k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_text !== 248'h0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_async: valid=%b count=%0d ready=%b text=%h, want 0/0/1/0",
               out_valid, out_count, in_ready, out_text);
    end
    // a byte offered while reset is held must be dropped
    in_valid = 1'b1; in_byte = 8'h99;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    exp_text = '0;
    for (int k = 0; k < 31; k++) begin
      exp_text[247-8*k -: 8] = 8'(8'h40 + k);
      send(8'(8'h40 + k), 1'b0);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_text !== exp_text || out_count !== 5'd31) begin
      tests_failed++;
      $display("FAIL mid_reset_clean: valid=%b count=%0d text=%h want %h",
               out_valid, out_count, out_text, exp_text);
    end
    step();
    // reset while holding a frame
    out_ready = 1'b0;
    send(8'h55, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_text !== 248'h0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_reset: valid=%b count=%0d ready=%b, want 0/0/1",
               out_valid, out_count, in_ready);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_last_on_31();
    logic [247:0] exp_text;
    int extra;
    exp_text = '0;
    extra = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 31; k++) begin
      exp_text[247-8*k -: 8] = 8'(8'h10 + k);
      send(8'(8'h10 + k), (k == 30) ? 1'b1 : 1'b0);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_text !== exp_text || out_count !== 5'd31) begin
      tests_failed++;
      $display("FAIL last31_frame: valid=%b count=%0d text=%h want %h",
               out_valid, out_count, out_text, exp_text);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid !== 1'b0) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL last31_no_extra: %0d extra valid cycles, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_last_on_31();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
